pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Program-counter and next-PC sequencer for the 16-bit single-cycle CPU.
//  Consumes the ALU zero flag and the decoded opcode/offset fields of the executing
//  instruction, and produces the PC that drives instruction fetch.
//  Owns branch/jump redirection, stall hold, a HALT state, and retire/taken counters.
// PARAMETERS
//  RESET_PC  16'h0000  PC loaded on reset
//  OFFSET_W  6         width of signed (two's-complement) beq offset
//  JUMP_W    12        width of absolute jump target field (low PC bits)
// PORTS
//  clk          in   1         rising-edge clock
//  rst          in   1         synchronous reset, active-high
//  exec_en      in   1         instruction at pc is valid and executing this cycle
//  opcode       in   3         opcode of executing instr (3'b100 beq, 3'b111 jump, others sequential)
//  zero         in   1         ALU zero flag, same cycle (combinational)
//  br_offset    in   OFFSET_W  signed beq offset, relative to pc+1
//  jump_target  in   JUMP_W    absolute jump target low bits
//  halt_req     in   1         executing instruction is a halt (qualified by exec_en)
//  stall        in   1         freeze: hold PC, state and counters
//  resume       in   1         leave HALT
//  pc           out  16        current PC (registered)
//  pc_plus1     out  16        pc+1 mod 2^16 (combinational, for link/next)
//  state        out  2         2'b00 RESET, 2'b01 RUN, 2'b10 HALT
//  halted       out  1         1 iff state==HALT
//  retired      out  16        retired-instruction count, saturates at 16'hFFFF
//  taken        out  16        taken beq + jump count, saturates at 16'hFFFF
// BEHAVIOUR
//  - rst=1 at edge: pc<=RESET_PC, state<=RESET, counters<=0, halted=0; overrides all, incl. mid-HALT/mid-stall
//  - RESET: lasts exactly one cycle after rst drops, no retire, ignores stall/resume/exec_en -> RUN
//  - RUN, priority per edge: stall > !exec_en > halt_req > beq/jump > sequential
//    - stall=1: pc, state, counters unchanged
//    - exec_en=0: hold pc, no counter change
//    - halt_req: instr retires (retired+1), pc<=pc_plus1, state<=HALT
//    - opcode 100 & zero: pc<=pc_plus1+sext(br_offset), taken+1, retired+1
//    - opcode 100 & !zero: pc<=pc_plus1, retired+1
//    - opcode 111: pc<={pc_plus1[15:JUMP_W],jump_target}, taken+1, retired+1
//    - other opcodes: pc<=pc_plus1, retired+1
//  - HALT: pc, counters frozen; exec_en/halt_req/opcode/stall ignored; resume=1 -> RUN at next edge
//  - Latency: redirect visible on pc at the edge ending the executing cycle; no bubbles
//  - Arithmetic mod 2^16: 16'hFFFF+1=16'h0000; branch target wraps both directions
//  - Counters saturate at 16'hFFFF; never wrap
// TESTING
//  1. rst 2 cycles, release, exec_en=1 opcode 000 x3 -> 1 cycle RESET pc=0000, then pc 0001,0002,0003; retired=3
//  2. pc=0010 opcode 100 zero=1 br_offset=6'h3E -> pc=000F, taken=1; repeat at 0010 with zero=0 -> pc=0011
//  3. pc=FFFF opcode 000 -> pc=0000; pc=1234 opcode 111 jump_target=ABC -> pc=1ABC
//  4. stall=1 with halt_req=1, opcode 100, zero=1 -> pc, state, retired, taken unchanged
//  5. halt_req at pc=0020 -> pc=0021, halted=1; 5 cycles opcode 111 exec_en=1 -> pc stays 0021; resume -> state=RUN next edge
//  6. retired preset to FFFE via 65534 ops, 3 more retires -> retired=FFFF; rst in HALT -> pc=RESET_PC, counters 0

Source files
------------

// File: rtl/pc_sequencer.sv
// Program counter and next-PC sequencer for the 16-bit single-cycle CPU.
// Handles branch/jump redirection, stall hold, HALT, and the saturating retire/taken counters.
module pc_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          OFFSET_W = 6,
  parameter int          JUMP_W   = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                exec_en,
  input  logic [2:0]          opcode,
  input  logic                zero,
  input  logic [OFFSET_W-1:0] br_offset,
  input  logic [JUMP_W-1:0]   jump_target,
  input  logic                halt_req,
  input  logic                stall,
  input  logic                resume,
  output logic [15:0]         pc,
  output logic [15:0]         pc_plus1,
  output logic [1:0]          state,
  output logic                halted,
  output logic [15:0]         retired,
  output logic [15:0]         taken
);

  // state    | meaning
  // ST_RESET | one settling cycle after rst drops, nothing executes
  // ST_RUN   | executing; stall and exec_en gate each edge
  // ST_HALT  | pc and counters frozen until resume
  typedef enum logic [1:0] {
    ST_RESET = 2'b00,
    ST_RUN   = 2'b01,
    ST_HALT  = 2'b10
  } state_t;

  localparam logic [2:0] OP_BEQ  = 3'b100;
  localparam logic [2:0] OP_JUMP = 3'b111;

  state_t      state_q, state_d;
  logic [15:0] pc_d, retired_d, taken_d;
  logic [15:0] br_target, jump_pc, retired_inc, taken_inc;

  assign pc_plus1  = pc + 16'd1;
  // Both targets derive from pc+1 so wrap at 16'hFFFF falls out of the adder.
  assign br_target = pc_plus1 + {{(16-OFFSET_W){br_offset[OFFSET_W-1]}}, br_offset};
  assign jump_pc   = {pc_plus1[15:JUMP_W], jump_target};

  assign retired_inc = (retired == 16'hFFFF) ? retired : retired + 16'd1;
  assign taken_inc   = (taken == 16'hFFFF) ? taken : taken + 16'd1;

  assign state  = state_q;
  assign halted = (state_q == ST_HALT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RESET;
      pc      <= RESET_PC;
      retired <= 16'h0000;
      taken   <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc      <= pc_d;
      retired <= retired_d;
      taken   <= taken_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc;
    retired_d = retired;
    taken_d   = taken;
    case (state_q)
      ST_RESET: state_d = ST_RUN;
      ST_RUN: begin
        if (!stall && exec_en) begin
          retired_d = retired_inc;
          pc_d      = pc_plus1;
          if (halt_req) begin
            state_d = ST_HALT;
          end else if (opcode == OP_BEQ && zero) begin
            pc_d    = br_target;
            taken_d = taken_inc;
          end else if (opcode == OP_JUMP) begin
            pc_d    = jump_pc;
            taken_d = taken_inc;
          end
        end
      end
      ST_HALT: begin
        if (resume) state_d = ST_RUN;
      end
      default: state_d = ST_RESET;
    endcase
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed scenarios plus random traffic,
// all predicted by an arithmetic reference model and checked by a separate monitor.
module tb_pc_sequencer;

  logic        clk;
  logic        rst;
  logic        exec_en;
  logic [2:0]  opcode;
  logic        zero;
  logic [5:0]  br_offset;
  logic [11:0] jump_target;
  logic        halt_req;
  logic        stall;
  logic        resume;
  logic [15:0] pc;
  logic [15:0] pc_plus1;
  logic [1:0]  state;
  logic        halted;
  logic [15:0] retired;
  logic [15:0] taken;

  pc_sequencer #(.RESET_PC(16'h0000), .OFFSET_W(6), .JUMP_W(12)) dut (
    .clk(clk), .rst(rst), .exec_en(exec_en), .opcode(opcode), .zero(zero),
    .br_offset(br_offset), .jump_target(jump_target), .halt_req(halt_req),
    .stall(stall), .resume(resume), .pc(pc), .pc_plus1(pc_plus1), .state(state),
    .halted(halted), .retired(retired), .taken(taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] pc;
    logic [1:0]  st;
    logic [15:0] ret;
    logic [15:0] tak;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  // reference model: mode 0 = reset cycle, 1 = run, 2 = halt
  int m_pc, m_mode, m_ret, m_tak;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic en, input logic [2:0] op, input logic z,
                      input logic [5:0] off, input logic [11:0] jt, input logic h,
                      input logic s, input logic res);
    int nxt, soff;
    exp_t e;
    @(negedge clk);
    rst = r; exec_en = en; opcode = op; zero = z; br_offset = off;
    jump_target = jt; halt_req = h; stall = s; resume = res;
    if (r) begin
      m_pc = 0; m_mode = 0; m_ret = 0; m_tak = 0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 2) begin
      if (res) m_mode = 1;
    end else if (!s && en) begin
      nxt  = (m_pc + 1) % 65536;
      soff = (int'(off) >= 32) ? int'(off) - 64 : int'(off);
      if (m_ret < 65535) m_ret++;
      if (h) begin
        m_pc = nxt; m_mode = 2;
      end else if (op == 3'd4 && z) begin
        m_pc = (nxt + soff + 65536) % 65536;
        if (m_tak < 65535) m_tak++;
      end else if (op == 3'd7) begin
        m_pc = (nxt / 4096) * 4096 + int'(jt);
        if (m_tak < 65535) m_tak++;
      end else begin
        m_pc = nxt;
      end
    end
    e.pc  = 16'(m_pc);
    e.st  = 2'(m_mode);
    e.ret = 16'(m_ret);
    e.tak = 16'(m_tak);
    q.push_back(e);
  endtask

  task automatic exe(input logic [2:0] op, input logic z, input logic [5:0] off, input logic [11:0] jt);
    step(1'b0, 1'b1, op, z, off, jt, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      chk("mon_pc", pc, mon_e.pc);
      chk("mon_pc_plus1", pc_plus1, mon_e.pc + 16'd1);
      chk("mon_state", {14'b0, state}, {14'b0, mon_e.st});
      chk("mon_halted", {15'b0, halted}, {15'b0, (mon_e.st == 2'b10)});
      chk("mon_retired", retired, mon_e.ret);
      chk("mon_taken", taken, mon_e.tak);
    end
  end

  initial begin
    int snap_ret, snap_tak;
    rst = 1'b1; exec_en = 1'b0; opcode = 3'd0; zero = 1'b0; br_offset = 6'd0;
    jump_target = 12'd0; halt_req = 1'b0; stall = 1'b0; resume = 1'b0;
    m_pc = 0; m_mode = 0; m_ret = 0; m_tak = 0;

    // reset, then the RESET cycle ignores stall/resume/exec_en
    step(1'b1, 1'b0, 3'd0, 1'b0, 6'd0, 12'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 3'd0, 1'b0, 6'd0, 12'd0, 1'b0, 1'b0, 1'b0);
    settle();
    chk("rst_state", {14'b0, state}, 16'h0000);
    chk("rst_pc", pc, 16'h0000);
    step(1'b0, 1'b1, 3'd0, 1'b0, 6'd0, 12'd0, 1'b1, 1'b1, 1'b1);
    settle();
    chk("reset_cycle_state", {14'b0, state}, 16'h0001);
    chk("reset_cycle_pc", pc, 16'h0000);
    chk("reset_cycle_retired", retired, 16'h0000);
    repeat (3) exe(3'd0, 1'b0, 6'd0, 12'd0);
    settle();
    chk("seq_pc", pc, 16'h0003);
    chk("seq_retired", retired, 16'h0003);

    // beq taken with negative offset, then not taken
    repeat (13) exe(3'd0, 1'b0, 6'd0, 12'd0);
    exe(3'd4, 1'b1, 6'h3E, 12'd0);
    settle();
    chk("beq_taken_pc", pc, 16'h000F);
    chk("beq_taken_cnt", taken, 16'h0001);
    exe(3'd0, 1'b0, 6'd0, 12'd0);
    exe(3'd4, 1'b0, 6'h3E, 12'd0);
    settle();
    chk("beq_not_taken_pc", pc, 16'h0011);
    chk("beq_not_taken_cnt", taken, 16'h0001);

    // wrap both directions, then jump keeps upper bits of pc+1
    exe(3'd7, 1'b0, 6'd0, 12'h000);
    exe(3'd4, 1'b1, 6'h3E, 12'd0);
    settle();
    chk("beq_wrap_down", pc, 16'hFFFF);
    exe(3'd0, 1'b0, 6'd0, 12'd0);
    settle();
    chk("seq_wrap_up", pc, 16'h0000);
    exe(3'd7, 1'b0, 6'd0, 12'hFFF);
    exe(3'd0, 1'b0, 6'd0, 12'd0);
    exe(3'd7, 1'b0, 6'd0, 12'h234);
    settle();
    chk("jump_1234", pc, 16'h1234);
    exe(3'd7, 1'b0, 6'd0, 12'hABC);
    settle();
    chk("jump_1abc", pc, 16'h1ABC);
    exe(3'd4, 1'b1, 6'h1F, 12'd0);
    settle();
    chk("beq_pos_max", pc, 16'h1ADC);

    // stall beats halt_req and a taken beq; exec_en=0 holds
    snap_ret = m_ret; snap_tak = m_tak;
    step(1'b0, 1'b1, 3'd4, 1'b1, 6'h3E, 12'd0, 1'b1, 1'b1, 1'b0);
    settle();
    chk("stall_pc", pc, 16'h1ADC);
    chk("stall_state", {14'b0, state}, 16'h0001);
    chk("stall_retired", retired, 16'(snap_ret));
    chk("stall_taken", taken, 16'(snap_tak));
    step(1'b0, 1'b0, 3'd7, 1'b0, 6'd0, 12'h555, 1'b1, 1'b0, 1'b0);
    settle();
    chk("noexec_pc", pc, 16'h1ADC);
    chk("noexec_retired", retired, 16'(snap_ret));

    // halt, ignore traffic, resume even while stall is high
    exe(3'd7, 1'b0, 6'd0, 12'h020);
    step(1'b0, 1'b1, 3'd0, 1'b0, 6'd0, 12'd0, 1'b1, 1'b0, 1'b0);
    settle();
    chk("halt_pc", pc, 16'h1021);
    chk("halt_flag", {15'b0, halted}, 16'h0001);
    repeat (5) step(1'b0, 1'b1, 3'd7, 1'b0, 6'd0, 12'h777, 1'b1, 1'b0, 1'b0);
    settle();
    chk("halt_frozen_pc", pc, 16'h1021);
    step(1'b0, 1'b0, 3'd0, 1'b0, 6'd0, 12'd0, 1'b0, 1'b1, 1'b1);
    settle();
    chk("resume_state", {14'b0, state}, 16'h0001);
    exe(3'd0, 1'b0, 6'd0, 12'd0);
    settle();
    chk("after_resume_pc", pc, 16'h1022);

    // random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), 3'($urandom),
           1'($urandom), 6'($urandom), 12'($urandom), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
    end

    // retire counter saturation, then reset out of HALT
    step(1'b1, 1'b0, 3'd0, 1'b0, 6'd0, 12'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 3'd0, 1'b0, 6'd0, 12'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 65534; i++) begin
      exe(3'($urandom_range(0, 7) == 7 ? 3'd7 : 3'($urandom_range(0, 6))),
          1'($urandom), 6'($urandom), 12'($urandom));
    end
    settle();
    chk("retired_fffe", retired, 16'hFFFE);
    exe(3'd0, 1'b0, 6'd0, 12'd0);
    settle();
    chk("retired_ffff", retired, 16'hFFFF);
    exe(3'd7, 1'b0, 6'd0, 12'h100);
    exe(3'd0, 1'b0, 6'd0, 12'd0);
    settle();
    chk("retired_saturated", retired, 16'hFFFF);
    step(1'b0, 1'b1, 3'd0, 1'b0, 6'd0, 12'd0, 1'b1, 1'b0, 1'b0);
    settle();
    chk("sat_halted", {15'b0, halted}, 16'h0001);
    step(1'b1, 1'b1, 3'd7, 1'b0, 6'd0, 12'd0, 1'b0, 1'b1, 1'b1);
    settle();
    chk("rst_in_halt_pc", pc, 16'h0000);
    chk("rst_in_halt_retired", retired, 16'h0000);
    chk("rst_in_halt_taken", taken, 16'h0000);
    chk("rst_in_halt_state", {14'b0, state}, 16'h0000);
    chk("rst_in_halt_halted", {15'b0, halted}, 16'h0000);

    repeat (2) @(posedge clk);
    #3;
    chk("scoreboard_drained", 16'(q.size()), 16'h0000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
